// File: rtl/mem_chk_pkg.sv
// mem_pattern_checker shared types and pattern helper.
// Imported by the checker top and its compare stage.
package mem_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  // Full-width product; callers truncate to the RAM data width.
  function automatic logic [31:0] pattern(
    input logic [31:0] addr,
    input logic [31:0] seed,
    input logic [31:0] mult
  );
    return addr * mult + seed;
  endfunction

endpackage

// File: rtl/mem_pattern_checker_if.sv
// RAM-side bus between the pattern checker and a
// single-port synchronous RAM with 1-cycle read latency.
interface mem_pattern_checker_if #(
  parameter int Addr_width = 10,
  parameter int Data_width = 8
) ();

  logic                  mem_wr;
  logic                  mem_rd;
  logic [Addr_width-1:0] mem_addr;
  logic [Data_width-1:0] mem_din;
  logic [Data_width-1:0] mem_dout;

  modport master (
    output mem_wr,
    output mem_rd,
    output mem_addr,
    output mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_wr,
    input  mem_rd,
    input  mem_addr,
    input  mem_din,
    output mem_dout
  );

endinterface

// File: rtl/mem_chk_cmp.sv
// Readback compare stage: mismatch count with saturation
// and capture of the first failing address.
module mem_chk_cmp
  import mem_chk_pkg::*;
#(
  parameter int Addr_width = 10,
  parameter int Data_width = 8,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  cmp_valid,
  input  logic [Addr_width-1:0] cmp_addr,
  input  logic [Data_width-1:0] mem_dout,
  input  logic [Data_width-1:0] exp_data,
  output logic                  mismatch,
  output logic [Cnt_width-1:0]  err_count,
  output logic [Addr_width-1:0] first_err_addr
);

  assign mismatch = cmp_valid && (mem_dout != exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_count != '1)
        err_count <= err_count + Cnt_width'(1);
      if (err_count == '0)
        first_err_addr <= cmp_addr;
    end
  end

endmodule

// File: rtl/mem_pattern_checker.sv
// Self-test engine: fills the RAM with a seeded linear
// pattern, reads it back and reports mismatches.
module mem_pattern_checker
  import mem_chk_pkg::*;
#(
  parameter int Addr_width = 10,
  parameter int Data_width = 8,
  parameter int Depth      = 1024,
  parameter int Mult       = 3,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Data_width-1:0] seed,
  mem_pattern_checker_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [Cnt_width-1:0]  err_count,
  output logic [Addr_width-1:0] first_err_addr
);

  localparam logic [Addr_width-1:0] LAST =
    Addr_width'(Depth - 1);

  state_t                state;
  logic [Data_width-1:0] seed_q;
  logic                  cmp_valid;
  logic [Addr_width-1:0] cmp_addr;
  logic [Data_width-1:0] cmp_exp;
  logic [Addr_width-1:0] addr_inc;
  logic                  accept;
  logic                  mismatch;

  function automatic logic [Data_width-1:0] pat(
    input logic [Addr_width-1:0] a,
    input logic [Data_width-1:0] s
  );
    return Data_width'(pattern(32'(a), 32'(s), 32'(Mult)));
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign addr_inc = mem.mem_addr + Addr_width'(1);
  assign cmp_exp  = pat(cmp_addr, seed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      seed_q       <= '0;
      mem.mem_wr   <= 1'b0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      cmp_valid    <= 1'b0;
      cmp_addr     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            seed_q       <= seed;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            mem.mem_wr   <= 1'b1;
            mem.mem_addr <= '0;
            mem.mem_din  <= pat('0, seed);
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (mem.mem_addr == LAST) begin
            mem.mem_wr   <= 1'b0;
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= '0;
            state        <= READ;
          end else begin
            mem.mem_addr <= addr_inc;
            mem.mem_din  <= pat(addr_inc, seed_q);
          end
        end
        READ: begin
          cmp_valid <= mem.mem_rd;
          cmp_addr  <= mem.mem_addr;
          if (mem.mem_rd) begin
            if (mem.mem_addr == LAST) begin
              mem.mem_rd   <= 1'b0;
              mem.mem_addr <= '0;
            end else begin
              mem.mem_addr <= addr_inc;
            end
          end else begin
            // Drain edge: fold in the last compare result.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_chk_cmp #(
    .Addr_width (Addr_width),
    .Data_width (Data_width),
    .Cnt_width  (Cnt_width)
  ) u_cmp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (accept),
    .cmp_valid      (cmp_valid),
    .cmp_addr       (cmp_addr),
    .mem_dout       (mem.mem_dout),
    .exp_data       (cmp_exp),
    .mismatch       (mismatch),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule
